// File: rtl/issue_sched.sv
// issue_sched: in-order issue buffer between instruction fetch and decode.
//
// Fetched instructions are queued in a 2^IQ_LOG entry FIFO. The head is
// released to the decoder only when the ROB has a free entry and the head's
// target station (RS for ALU/branch/jump, LSB for load/store) has a free
// entry. Free entries are tracked with local credit counters. Each
// dispatched instruction gets the next ROB tag. A rollback flushes
// everything and restores all credits.
//
// Ports:
//   clk_i, rst_ni            clock (rising edge), async active-low reset
//   rdy_i                    global enable, 0 freezes every register
//   rollback_i               mispredict flush pulse
//   fetch_*_i                push strobe and payload from fetch
//   iq_full_o                registered queue-full flag for fetch
//   dec_*_o                  dispatch strobe, payload and ROB tag
//   rs_release_i             one RS entry freed
//   lsb_release_i            one LSB entry freed
//   rob_commit_i             one ROB entry committed
//   stall_cnt_o              blocked-head cycle counter
//
// Build option: define ISSUE_SCHED_STALL_CNT_EN to add stall_cnt_o and its
// counter. Without it the port and logic are absent.

module issue_sched #(
   parameter int IQ_LOG   = 2,
   parameter int ROB_LOG  = 4,
   parameter int RS_SIZE  = 16,
   parameter int LSB_SIZE = 16
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               rdy_i,
   input  logic               rollback_i,
   input  logic               fetch_valid_i,
   input  logic [31:0]        fetch_inst_i,
   input  logic [31:0]        fetch_pc_i,
   input  logic               fetch_pre_j_i,
   output logic               iq_full_o,
   output logic               dec_valid_o,
   output logic [31:0]        dec_inst_o,
   output logic [31:0]        dec_pc_o,
   output logic               dec_pre_j_o,
   output logic [ROB_LOG-1:0] dec_rob_pos_o,
   input  logic               rs_release_i,
   input  logic               lsb_release_i,
   input  logic               rob_commit_i
`ifdef ISSUE_SCHED_STALL_CNT_EN
   ,
   output logic [31:0]        stall_cnt_o
`endif
);

   localparam int IQ_DEPTH = 1 << IQ_LOG;
   localparam int ROB_SIZE = 1 << ROB_LOG;
   localparam int CW = IQ_LOG + 1;
   localparam int RW = ROB_LOG + 1;
   localparam int SW = $clog2(RS_SIZE + 1);
   localparam int LW = $clog2(LSB_SIZE + 1);
   localparam logic [RW-1:0] ROB_INIT = RW'(ROB_SIZE);
   localparam logic [SW-1:0] RS_INIT  = SW'(RS_SIZE);
   localparam logic [LW-1:0] LSB_INIT = LW'(LSB_SIZE);

   logic [31:0] iq_inst_q [IQ_DEPTH];
   logic [31:0] iq_pc_q   [IQ_DEPTH];
   logic        iq_prej_q [IQ_DEPTH];

   logic [IQ_LOG-1:0]  head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               iq_full_q, iq_full_d;
   logic               dec_valid_q, dec_valid_d;
   logic [31:0]        dec_inst_q, dec_inst_d, dec_pc_q, dec_pc_d;
   logic               dec_prej_q, dec_prej_d;
   logic [ROB_LOG-1:0] dec_pos_q, dec_pos_d, rob_tail_q, rob_tail_d;
   logic [RW-1:0]      rob_cr_q, rob_cr_d;
   logic [SW-1:0]      rs_cr_q, rs_cr_d;
   logic [LW-1:0]      lsb_cr_q, lsb_cr_d;

   logic [31:0] head_inst;
   logic        head_is_lsb, cls_ok, do_push, do_pop;

   assign head_inst   = iq_inst_q[head_q];
   assign head_is_lsb = (head_inst[6:0] == 7'b0000011) || (head_inst[6:0] == 7'b0100011);
   assign cls_ok      = head_is_lsb ? (lsb_cr_q != '0) : (rs_cr_q != '0);

   // Decisions use only registered credits; a same-cycle release never bypasses.
   assign do_push = rdy_i && !rollback_i && fetch_valid_i && !iq_full_q;
   assign do_pop  = rdy_i && !rollback_i && (cnt_q != '0) && (rob_cr_q != '0) && cls_ok;

   always_comb begin
      head_d      = head_q;
      tail_d      = tail_q;
      cnt_d       = cnt_q;
      dec_valid_d = dec_valid_q;
      dec_inst_d  = dec_inst_q;
      dec_pc_d    = dec_pc_q;
      dec_prej_d  = dec_prej_q;
      dec_pos_d   = dec_pos_q;
      rob_tail_d  = rob_tail_q;
      rob_cr_d    = rob_cr_q;
      rs_cr_d     = rs_cr_q;
      lsb_cr_d    = lsb_cr_q;
      if (rdy_i) begin
         if (rollback_i) begin
            head_d      = '0;
            tail_d      = '0;
            cnt_d       = '0;
            dec_valid_d = 1'b0;
            rob_tail_d  = '0;
            rob_cr_d    = ROB_INIT;
            rs_cr_d     = RS_INIT;
            lsb_cr_d    = LSB_INIT;
         end else begin
            if (do_push) tail_d = tail_q + IQ_LOG'(1);
            if (do_pop) begin
               head_d     = head_q + IQ_LOG'(1);
               dec_inst_d = head_inst;
               dec_pc_d   = iq_pc_q[head_q];
               dec_prej_d = iq_prej_q[head_q];
               dec_pos_d  = rob_tail_q;
               rob_tail_d = rob_tail_q + ROB_LOG'(1);
            end
            dec_valid_d = do_pop;
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);

            // Release at the initial value is a protocol error: saturate.
            if (do_pop && !rob_commit_i)
               rob_cr_d = rob_cr_q - RW'(1);
            else if (!do_pop && rob_commit_i && rob_cr_q != ROB_INIT)
               rob_cr_d = rob_cr_q + RW'(1);

            if (do_pop && !head_is_lsb && !rs_release_i)
               rs_cr_d = rs_cr_q - SW'(1);
            else if (!(do_pop && !head_is_lsb) && rs_release_i && rs_cr_q != RS_INIT)
               rs_cr_d = rs_cr_q + SW'(1);

            if (do_pop && head_is_lsb && !lsb_release_i)
               lsb_cr_d = lsb_cr_q - LW'(1);
            else if (!(do_pop && head_is_lsb) && lsb_release_i && lsb_cr_q != LSB_INIT)
               lsb_cr_d = lsb_cr_q + LW'(1);
         end
      end
      iq_full_d = (cnt_d == CW'(IQ_DEPTH));
   end

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         iq_inst_q[tail_q] <= fetch_inst_i;
         iq_pc_q[tail_q]   <= fetch_pc_i;
         iq_prej_q[tail_q] <= fetch_pre_j_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q      <= '0;
         tail_q      <= '0;
         cnt_q       <= '0;
         iq_full_q   <= 1'b0;
         dec_valid_q <= 1'b0;
         dec_inst_q  <= '0;
         dec_pc_q    <= '0;
         dec_prej_q  <= 1'b0;
         dec_pos_q   <= '0;
         rob_tail_q  <= '0;
         rob_cr_q    <= ROB_INIT;
         rs_cr_q     <= RS_INIT;
         lsb_cr_q    <= LSB_INIT;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         cnt_q       <= cnt_d;
         iq_full_q   <= iq_full_d;
         dec_valid_q <= dec_valid_d;
         dec_inst_q  <= dec_inst_d;
         dec_pc_q    <= dec_pc_d;
         dec_prej_q  <= dec_prej_d;
         dec_pos_q   <= dec_pos_d;
         rob_tail_q  <= rob_tail_d;
         rob_cr_q    <= rob_cr_d;
         rs_cr_q     <= rs_cr_d;
         lsb_cr_q    <= lsb_cr_d;
      end
   end

   assign iq_full_o     = iq_full_q;
   assign dec_valid_o   = dec_valid_q;
   assign dec_inst_o    = dec_inst_q;
   assign dec_pc_o      = dec_pc_q;
   assign dec_pre_j_o   = dec_prej_q;
   assign dec_rob_pos_o = dec_pos_q;

`ifdef ISSUE_SCHED_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (rdy_i && !rollback_i && (cnt_q != '0) && !do_pop)
         stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) stall_cnt_q <= '0;
      else         stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_issue_sched.sv
module tb_issue_sched;
   localparam int TW = 4;
   localparam logic [31:0] ALU   = 32'h002081B3;
   localparam logic [31:0] LOAD  = 32'h0000A103;
   localparam logic [31:0] STORE = 32'h0020A023;

   logic          clk = 1'b0;
   logic          rst, rdy, rollback;
   logic          fetch_valid, fetch_pre_j;
   logic [31:0]   fetch_inst, fetch_pc;
   logic          iq_full, dec_valid, dec_pre_j;
   logic [31:0]   dec_inst, dec_pc;
   logic [TW-1:0] dec_rob_pos;
   logic          rs_release, lsb_release, rob_commit;
`ifdef ISSUE_SCHED_STALL_CNT_EN
   logic [31:0]   stall_cnt;
`endif

   always #5 clk = ~clk;

   issue_sched dut (
      .clk_i(clk), .rst_ni(rst), .rdy_i(rdy), .rollback_i(rollback),
      .fetch_valid_i(fetch_valid), .fetch_inst_i(fetch_inst),
      .fetch_pc_i(fetch_pc), .fetch_pre_j_i(fetch_pre_j),
      .iq_full_o(iq_full), .dec_valid_o(dec_valid), .dec_inst_o(dec_inst),
      .dec_pc_o(dec_pc), .dec_pre_j_o(dec_pre_j), .dec_rob_pos_o(dec_rob_pos),
      .rs_release_i(rs_release), .lsb_release_i(lsb_release),
      .rob_commit_i(rob_commit)
`ifdef ISSUE_SCHED_STALL_CNT_EN
      , .stall_cnt_o(stall_cnt)
`endif
   );

   typedef struct packed {
      logic [31:0]   inst;
      logic [31:0]   pc;
      logic          pj;
      logic [TW-1:0] tag;
   } exp_t;

   exp_t          exp_q[$];
   int            checks = 0;
   int            errors = 0;
   int            disp_cnt = 0;
   logic [TW-1:0] tag_ctr = '0;
   logic          last_rdy = 1'b0;

   // Monitor: a dispatch is a dec_valid following an enabled edge.
   always @(posedge clk) last_rdy <= rdy;

   always @(negedge clk) begin
      exp_t e;
      if (rst === 1'b1 && dec_valid === 1'b1 && last_rdy) begin
         checks++;
         disp_cnt++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL dispatch_unexpected: got pc=%h inst=%h tag=%0d, required none", dec_pc, dec_inst, dec_rob_pos);
         end else begin
            e = exp_q.pop_front();
            if (dec_inst !== e.inst || dec_pc !== e.pc || dec_pre_j !== e.pj || dec_rob_pos !== e.tag) begin
               errors++;
               $display("FAIL dispatch_data: got inst=%h pc=%h pj=%b tag=%0d, required inst=%h pc=%h pj=%b tag=%0d",
                        dec_inst, dec_pc, dec_pre_j, dec_rob_pos, e.inst, e.pc, e.pj, e.tag);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic set_idle();
      fetch_valid = 1'b0; fetch_inst = '0; fetch_pc = '0; fetch_pre_j = 1'b0;
      rs_release = 1'b0; lsb_release = 1'b0; rob_commit = 1'b0; rollback = 1'b0;
   endtask

   // One clock of stimulus; acc says whether the bench expects the push to land.
   task automatic step(input bit fv, input logic [31:0] inst, input logic [31:0] pc,
                       input bit pj, input bit acc, input bit rsr, input bit lsbr,
                       input bit com, input bit rb);
      exp_t e;
      fetch_valid = fv; fetch_inst = inst; fetch_pc = pc; fetch_pre_j = pj;
      rs_release = rsr; lsb_release = lsbr; rob_commit = com; rollback = rb;
      if (fv && acc) begin
         e.inst = inst; e.pc = pc; e.pj = pj; e.tag = tag_ctr;
         exp_q.push_back(e);
         tag_ctr++;
      end
      @(posedge clk);
      #1;
      set_idle();
      if (rb) begin
         exp_q.delete();
         tag_ctr = '0;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, '0, '0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic push(input logic [31:0] inst, input logic [31:0] pc, input bit pj, input bit com);
      step(1, inst, pc, pj, 1, 0, 0, com, 0);
   endtask

   task automatic wait_disp(input string name, input int target, input int budget);
      int k = 0;
      while (disp_cnt < target && k < budget) begin
         @(negedge clk);
         #1;
         k++;
      end
      chk(name, 32'(disp_cnt), 32'(target));
   endtask

   task automatic do_reset();
      set_idle();
      rdy = 1'b1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q.delete();
      tag_ctr = '0;
   endtask

   initial begin
      int base;
      rst = 1'b0; rdy = 1'b1;
      set_idle();
      do_reset();

      // Reset values
      chk("rst_iq_full", 32'(iq_full), 32'd0);
      chk("rst_dec_valid", 32'(dec_valid), 32'd0);
      chk("rst_dec_inst", dec_inst, 32'd0);
      chk("rst_dec_pc", dec_pc, 32'd0);
      chk("rst_dec_pre_j", 32'(dec_pre_j), 32'd0);
      chk("rst_dec_rob_pos", 32'(dec_rob_pos), 32'd0);
`ifdef ISSUE_SCHED_STALL_CNT_EN
      chk("rst_stall_cnt", stall_cnt, 32'd0);
`endif

      // Three ALU ops issue on consecutive cycles with tags 0,1,2
      base = disp_cnt;
      push(ALU, 32'h0, 0, 0);
      chk("alu_first_not_yet", 32'(dec_valid), 32'd0);
      push(ALU, 32'h4, 1, 0);
      chk("alu_valid_c1", 32'(dec_valid), 32'd1);
      push(ALU, 32'h8, 0, 0);
      chk("alu_valid_c2", 32'(dec_valid), 32'd1);
      idle(1);
      chk("alu_valid_c3", 32'(dec_valid), 32'd1);
      idle(1);
      chk("alu_valid_drop", 32'(dec_valid), 32'd0);
      chk("alu_three", 32'(disp_cnt), 32'(base + 3));
      // 13 rob/rs credits left: 13 more issue, the next one stalls
      for (int i = 0; i < 13; i++) push(ALU, 32'h10 + 32'(4 * i), 0, 0);
      push(ALU, 32'h100, 1, 0);
      wait_disp("rob_exhaust", base + 16, 20);
      idle(4);
      chk("rob_stall", 32'(disp_cnt), 32'(base + 16));
      step(0, '0, '0, 0, 0, 0, 0, 1, 0);   // rob credit back, rs still 0
      idle(3);
      chk("rs_still_stall", 32'(disp_cnt), 32'(base + 16));
      step(0, '0, '0, 0, 0, 1, 0, 0, 0);   // tag wraps to 0 on this one
      wait_disp("tag_wrap_issue", base + 17, 5);

      // LSB credits: 17 loads/stores, ROB kept topped up
      do_reset();
      base = disp_cnt;
      for (int i = 0; i < 17; i++) push((i % 2) ? STORE : LOAD, 32'h200 + 32'(4 * i), 0, 1);
      wait_disp("lsb_exhaust", base + 16, 20);
      idle(4);
      chk("lsb_stall", 32'(disp_cnt), 32'(base + 16));
      step(0, '0, '0, 0, 0, 0, 1, 0, 0);
      chk("lsb_release_same_edge", 32'(dec_valid), 32'd0);
      idle(1);
      chk("lsb_release_next", 32'(dec_valid), 32'd1);
      push(ALU, 32'h280, 0, 0);           // ALU not gated by exhausted LSB
      wait_disp("alu_after_lsb", base + 18, 5);

      // Full queue and dropped push
      do_reset();
      base = disp_cnt;
      for (int i = 0; i < 16; i++) push(LOAD, 32'h300 + 32'(4 * i), 0, 1);
      wait_disp("full_prep", base + 16, 20);
      for (int i = 0; i < 3; i++) push(LOAD, 32'h380 + 32'(4 * i), 1, 0);
      chk("iq_not_full_3", 32'(iq_full), 32'd0);
      push(LOAD, 32'h38C, 1, 0);
      chk("iq_full_4", 32'(iq_full), 32'd1);
      step(1, LOAD, 32'h3F0, 0, 0, 0, 0, 0, 0);
      chk("iq_full_hold", 32'(iq_full), 32'd1);
      for (int i = 0; i < 4; i++) step(0, '0, '0, 0, 0, 0, 1, 0, 0);
      wait_disp("full_drain", base + 20, 10);
      idle(5);
      chk("full_exact4", 32'(disp_cnt), 32'(base + 20));
      chk("iq_full_clear", 32'(iq_full), 32'd0);

      // Rollback with two queued entries and an RS release in the same cycle
      do_reset();
      base = disp_cnt;
      for (int i = 0; i < 16; i++) push(LOAD, 32'h400 + 32'(4 * i), 0, 1);
      wait_disp("rb_prep", base + 16, 20);
      push(LOAD, 32'h480, 0, 0);
      push(LOAD, 32'h484, 0, 0);
      step(1, LOAD, 32'h4F0, 0, 0, 1, 0, 0, 1);
      chk("rb_dec_valid", 32'(dec_valid), 32'd0);
      chk("rb_iq_full", 32'(iq_full), 32'd0);
      idle(3);
      chk("rb_no_issue", 32'(disp_cnt), 32'(base + 16));
      base = disp_cnt;
      for (int i = 0; i < 17; i++) push(ALU, 32'h500 + 32'(4 * i), 0, 1);
      wait_disp("rb_rs_16", base + 16, 20);
      idle(4);
      chk("rb_rs_not_17", 32'(disp_cnt), 32'(base + 16));
      step(0, '0, '0, 0, 0, 1, 0, 0, 0);
      wait_disp("rb_rs_release", base + 17, 5);

      // rdy=0 freezes everything, including dec_valid
      do_reset();
      base = disp_cnt;
      push(ALU, 32'h600, 1, 0);
      idle(1);
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) step(1, ALU, 32'h604, 0, 0, 1, 1, 1, 0);
      chk("frz_dec_valid", 32'(dec_valid), 32'd1);
      chk("frz_dec_pc", dec_pc, 32'h600);
      rdy = 1'b1;
      idle(1);
      chk("frz_release", 32'(dec_valid), 32'd0);
      idle(3);
      chk("frz_one_issue", 32'(disp_cnt), 32'(base + 1));

`ifdef ISSUE_SCHED_STALL_CNT_EN
      // Head blocked five cycles
      do_reset();
      base = disp_cnt;
      for (int i = 0; i < 17; i++) push(LOAD, 32'h700 + 32'(4 * i), 0, 1);
      idle(5);
      chk("stall_cnt_5", stall_cnt, 32'd5);
      chk("stall_issued", 32'(disp_cnt), 32'(base + 16));
      step(0, '0, '0, 0, 0, 0, 1, 0, 0);
      wait_disp("stall_release", base + 17, 5);
`endif

      // Asynchronous reset mid-run
      do_reset();
      base = disp_cnt;
      push(ALU, 32'h800, 1, 0);
      push(ALU, 32'h804, 1, 0);
      push(LOAD, 32'h808, 1, 0);
      wait_disp("mid_prep", base + 2, 5);
      chk("mid_prep_pos", 32'(dec_rob_pos), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("mid_iq_full", 32'(iq_full), 32'd0);
      chk("mid_dec_valid", 32'(dec_valid), 32'd0);
      chk("mid_dec_inst", dec_inst, 32'd0);
      chk("mid_dec_pc", dec_pc, 32'd0);
      chk("mid_dec_pre_j", 32'(dec_pre_j), 32'd0);
      chk("mid_dec_rob_pos", 32'(dec_rob_pos), 32'd0);
`ifdef ISSUE_SCHED_STALL_CNT_EN
      chk("mid_stall_cnt", stall_cnt, 32'd0);
`endif
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b1;
      idle(3);

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/issue_sched.md
# issue_sched

Issue scheduler between instruction fetch and the decoder. Buffers fetched instructions in a small in-order queue and releases the head to the decoder only when the ROB and the target station (RS for ALU/branch/jump, LSB for load/store) have a free entry, according to internal credit counters. It also allocates the ROB tag for each issued instruction and flushes everything on rollback.

## Interface
- `IQ_LOG`, 2: instruction queue depth = 2^IQ_LOG.
- `ROB_LOG`, 4: ROB entries = 2^ROB_LOG; tag width.
- `RS_SIZE`, 16: RS entries (initial RS credits).
- `LSB_SIZE`, 16: LSB entries (initial LSB credits).

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `rdy`  in  1  global enable; 0 freezes all state.
- `rollback`  in  1  mispredict flush pulse.
- `fetch_valid`  in  1  push strobe from IFetch.
- `fetch_inst`  in  32  instruction word.
- `fetch_pc`  in  32  instruction PC.
- `fetch_pre_j`  in  1  predicted-taken bit.
- `iq_full`  out  1  queue full; IFetch must not push.
- `dec_valid`  out  1  dispatch strobe to decoder (`inst_done`).
- `dec_inst`  out  32  dispatched instruction.
- `dec_pc`  out  32  dispatched PC.
- `dec_pre_j`  out  1  dispatched prediction bit.
- `dec_rob_pos`  out  ROB_LOG  ROB tag for the dispatched instruction.
- `rs_release`  in  1  one RS entry freed this cycle.
- `lsb_release`  in  1  one LSB entry freed this cycle.
- `rob_commit`  in  1  one ROB entry committed this cycle.
- `stall_cnt`  out  32  cycles with a valid head blocked by credits (only with `ISSUE_SCHED_STALL_CNT_EN`).

## Operation
- Reset values: queue empty, `iq_full`=0, `dec_valid`=0, `dec_inst`/`dec_pc`=0, `dec_pre_j`=0, `dec_rob_pos`=0, ROB tail=0, credits rob=2^ROB_LOG, rs=RS_SIZE, lsb=LSB_SIZE, `stall_cnt`=0.
- Push: `fetch_valid` && !`iq_full` writes the tail entry. A push while `iq_full`=1 is dropped with no state change.
- Class of head: opcode[6:0] 0000011 (load) or 0100011 (store) → LSB; all other opcodes → RS.
- Dispatch condition: queue non-empty && rob credit>0 && class credit>0 && !rollback. On dispatch: pop head, register head fields into `dec_*`, `dec_rob_pos`←tail, tail←tail+1 mod 2^ROB_LOG, decrement rob and class credit.
- `dec_valid` is 1 only in the cycle following a dispatch edge; otherwise 0. `dec_*` data holds its last value when `dec_valid`=0.
- Credits: next = cur − dispatch + release (per counter). Release and dispatch in the same cycle leave the count unchanged. A dispatch decision uses only the registered count; same-cycle release does not bypass.
- Credit overflow (release at max) is a protocol error; the counter saturates at its initial value.
- Rollback (has priority over all): queue emptied, `dec_valid`←0, ROB tail←0, all credits restored to initial values. Pushes and releases in the rollback cycle are ignored.
- `rdy`=0: every register holds its value, including `dec_valid`; no push, pop or credit change.

## Timing
- Push at edge t → entry is head at t; earliest dispatch edge t+1; `dec_valid` high after t+1.
- Sustained throughput: one dispatch per cycle while credits remain.
- `iq_full` is registered and reflects the count after the same edge; a push and a pop in one cycle when full are both legal only if `iq_full`=0 was sampled. Producers must rely on the registered flag.
- Tag wrap: after tag 2^ROB_LOG−1 the next tag is 0.

## Configuration
- `ISSUE_SCHED_STALL_CNT_EN` defined: `stall_cnt` exists and increments (wrap at 2^32) each `rdy` cycle in which the queue is non-empty, `rollback`=0, and no dispatch occurs. It is cleared only by reset.
- Not defined: port `stall_cnt` and its logic are absent; all other behaviour is identical.

## Test plan
- Reset then 3 pushes (PCs 0x0, 0x4, 0x8, ALU ops) → `dec_valid` on 3 consecutive cycles, tags 0, 1, 2; rs credits 13; rob credits 13.
- 17 consecutive loads with no `lsb_release` → 16 dispatch; the 17th stalls. One `lsb_release` → it dispatches the next cycle.
- 4 pushes with credits exhausted → `iq_full`=1. A 5th push is dropped. After credits return, exactly 4 instructions issue.
- 16 dispatches with `rob_commit` every cycle → tags 0..15 then wrap to 0 on the 17th.
- `rollback` with 2 queued entries and `rs_release` in the same cycle → queue empty, `dec_valid`=0, tail 0, rs credits = 16 (not 17).
- Macro on, head blocked for 5 cycles → `stall_cnt`=5. `rst`=0 mid-run → all outputs return to reset values immediately.
